// File: rtl/evm_ballot_unit.sv
// evm_ballot_unit: ballot-side front end of the voting machine.
// Arms on a ballot from the control unit, debounces four party buttons,
// accepts one clean press and hands a {party, voter_id} record to the tally
// unit over a valid/ack handshake.
// Optional feature macro: VOTER_LOCK_EN adds a voted-ID table and clear_ids.
module evm_ballot_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 255,
    parameter int ID_W            = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic            ballot_enable,
    input  logic [ID_W-1:0] voter_id,
    input  logic            push1,
    input  logic            push2,
    input  logic            push3,
    input  logic            push4,
    input  logic            vote_ack,
`ifdef VOTER_LOCK_EN
    input  logic            clear_ids,
`endif
    output logic            vote_valid,
    output logic [1:0]      vote_party,
    output logic [ID_W-1:0] vote_voter_id,
    output logic            ready_led,
    output logic            busy,
    output logic            reject,
    output logic [7:0]      vote_count
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DEBOUNCE,
        S_SEND,
        S_RELEASE
    } state_t;

    state_t            state, state_nxt;
    logic [DEB_W-1:0]  deb_cnt, deb_nxt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
    logic [3:0]        btn_sel, btn_nxt;
    logic [3:0]        buttons;
    logic              one_pressed;
    logic              deb_last;
    logic              tmo_hit;
    logic              id_locked;
    logic              latch_id;
    logic              latch_party;
    logic              reject_nxt;
    logic              count_inc;
    logic [1:0]        party_enc;

    assign buttons     = {push4, push3, push2, push1};
    assign one_pressed = (buttons != 4'b0000) && ((buttons & (buttons - 4'd1)) == 4'b0000);
    assign deb_last    = (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
    assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Encode the single pressed button into the two-bit party code
    always_comb begin
        party_enc = 2'd0;
        case (buttons)
            4'b0010: party_enc = 2'd1;
            4'b0100: party_enc = 2'd2;
            4'b1000: party_enc = 2'd3;
            default: party_enc = 2'd0;
        endcase
    end

`ifdef VOTER_LOCK_EN
    logic [2**ID_W-1:0] voted;
    logic               set_bit;

    assign id_locked = voted[voter_id];
    assign set_bit   = (state == S_SEND) && vote_ack && mode;

    // Voted-ID table: set on each accepted handshake, cleared by reset or clear_ids
    // NOTE: this table is reset explicitly because a stale bit would lock out a voter;
    // plain data storage elsewhere would not need a reset.
    always_ff @(posedge clk) begin
        if (!reset || clear_ids) begin
            voted <= '0;
        end else if (set_bit) begin
            voted[vote_voter_id] <= 1'b1;
        end
    end
`else
    assign id_locked = 1'b0;
`endif

    // State and counter register
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            deb_cnt <= '0;
            tmo_cnt <= '0;
            btn_sel <= 4'b0000;
        end else begin
            state   <= state_nxt;
            deb_cnt <= deb_nxt;
            tmo_cnt <= tmo_nxt;
            btn_sel <= btn_nxt;
        end
    end

    // Next-state, counter and event decode
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_nxt   = state;
        deb_nxt     = deb_cnt;
        tmo_nxt     = tmo_cnt;
        btn_nxt     = btn_sel;
        latch_id    = 1'b0;
        latch_party = 1'b0;
        reject_nxt  = 1'b0;
        count_inc   = 1'b0;

        case (state)
            S_IDLE: begin
                deb_nxt = '0;
                tmo_nxt = '0;
                if (ballot_enable) begin
                    if (id_locked) begin
                        reject_nxt = 1'b1;
                    end else begin
                        state_nxt = S_ARMED;
                        latch_id  = 1'b1;
                    end
                end
            end

            S_ARMED: begin
                tmo_nxt = tmo_cnt + TMO_W'(1);
                if (one_pressed) begin
                    btn_nxt = buttons;
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt   = S_SEND;
                        latch_party = 1'b1;
                        deb_nxt     = '0;
                    end else begin
                        state_nxt = S_DEBOUNCE;
                        deb_nxt   = DEB_W'(1);
                    end
                end
                // A vote completing on the same edge takes precedence over the timeout
                if (tmo_hit && !latch_party) begin
                    state_nxt  = S_IDLE;
                    reject_nxt = 1'b1;
                    deb_nxt    = '0;
                    tmo_nxt    = '0;
                end
            end

            S_DEBOUNCE: begin
                tmo_nxt = tmo_cnt + TMO_W'(1);
                if (buttons == btn_sel) begin
                    if (deb_last) begin
                        state_nxt   = S_SEND;
                        latch_party = 1'b1;
                        deb_nxt     = '0;
                    end else begin
                        deb_nxt = deb_cnt + DEB_W'(1);
                    end
                end else begin
                    state_nxt = S_ARMED;
                    deb_nxt   = '0;
                end
                if (tmo_hit && !latch_party) begin
                    state_nxt  = S_IDLE;
                    reject_nxt = 1'b1;
                    deb_nxt    = '0;
                    tmo_nxt    = '0;
                end
            end

            S_SEND: begin
                if (vote_ack) begin
                    state_nxt = S_RELEASE;
                    count_inc = 1'b1;
                    deb_nxt   = '0;
                end
            end

            S_RELEASE: begin
                if (buttons == 4'b0000) begin
                    if (deb_last) begin
                        state_nxt = S_IDLE;
                        deb_nxt   = '0;
                    end else begin
                        deb_nxt = deb_cnt + DEB_W'(1);
                    end
                end else begin
                    deb_nxt = '0;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                deb_nxt   = '0;
                tmo_nxt   = '0;
            end
        endcase

        // Leaving voting mode abandons everything silently
        if (!mode) begin
            state_nxt   = S_IDLE;
            deb_nxt     = '0;
            tmo_nxt     = '0;
            latch_id    = 1'b0;
            latch_party = 1'b0;
            reject_nxt  = 1'b0;
            count_inc   = 1'b0;
        end
    end

    // Registered outputs, derived from the next state so they track the state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            vote_valid    <= 1'b0;
            vote_party    <= 2'd0;
            vote_voter_id <= '0;
            ready_led     <= 1'b0;
            busy          <= 1'b0;
            reject        <= 1'b0;
            vote_count    <= 8'd0;
        end else begin
            vote_valid <= (state_nxt == S_SEND);
            ready_led  <= (state_nxt == S_ARMED) || (state_nxt == S_DEBOUNCE);
            busy       <= (state_nxt != S_IDLE);
            reject     <= reject_nxt;
            if (latch_id) begin
                vote_voter_id <= voter_id;
            end
            if (latch_party) begin
                vote_party <= party_enc;
            end
            if (count_inc && (vote_count != 8'hFF)) begin
                vote_count <= vote_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_evm_ballot_unit.sv
// tb_evm_ballot_unit: directed bench for evm_ballot_unit with a vote-record scoreboard.
// Honours VOTER_LOCK_EN when the design is built with it.
module tb_evm_ballot_unit;

    localparam int DEB  = 4;
    localparam int TMO  = 255;
    localparam int ID_W = 5;

    typedef struct packed {
        logic [1:0]      party;
        logic [ID_W-1:0] id;
    } rec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            mode;
    logic            ballot_enable;
    logic [ID_W-1:0] voter_id;
    logic            push1, push2, push3, push4;
    logic            vote_ack;
    logic            clear_ids;
    logic            vote_valid;
    logic [1:0]      vote_party;
    logic [ID_W-1:0] vote_voter_id;
    logic            ready_led;
    logic            busy;
    logic            reject;
    logic [7:0]      vote_count;

    int   n_cmp = 0;
    int   n_err = 0;
    rec_t sb[$];

    always #5 clk = ~clk;

    evm_ballot_unit #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO),
        .ID_W           (ID_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .ballot_enable(ballot_enable),
        .voter_id     (voter_id),
        .push1        (push1),
        .push2        (push2),
        .push3        (push3),
        .push4        (push4),
        .vote_ack     (vote_ack),
`ifdef VOTER_LOCK_EN
        .clear_ids    (clear_ids),
`endif
        .vote_valid   (vote_valid),
        .vote_party   (vote_party),
        .vote_voter_id(vote_voter_id),
        .ready_led    (ready_led),
        .busy         (busy),
        .reject       (reject),
        .vote_count   (vote_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_buttons(input logic [3:0] b);
        {push4, push3, push2, push1} = b;
    endtask

    // Issue a ballot; returns on the negedge after the arming edge
    task automatic run_ballot(input logic [ID_W-1:0] id);
        ballot_enable = 1'b1;
        voter_id      = id;
        @(negedge clk);
        ballot_enable = 1'b0;
    endtask

    // Wait for vote_valid, check its latency and the record against the scoreboard
    task automatic wait_valid(input string tag, input int exp_lat);
        int   k;
        rec_t e;
        k = 0;
        while (!vote_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, exp_lat);
        if (vote_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_party"}, vote_party, e.party);
            check({tag, "_id"}, vote_voter_id, e.id);
        end
    endtask

    task automatic ack_vote();
        vote_ack = 1'b1;
        @(negedge clk);
        vote_ack = 1'b0;
    endtask

    // Release all buttons and expect IDLE after DEB quiet cycles
    task automatic release_to_idle(input string tag);
        int k;
        set_buttons(4'b0000);
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_release"}, k, DEB);
    endtask

    task automatic full_vote(input string tag, input logic [ID_W-1:0] id, input logic [1:0] party);
        run_ballot(id);
        set_buttons(4'b0001 << party);
        sb.push_back('{party: party, id: id});
        wait_valid(tag, DEB);
        ack_vote();
        release_to_idle(tag);
    endtask

    initial begin
        reset = 1'b0; mode = 1'b1; ballot_enable = 1'b0; voter_id = '0;
        vote_ack = 1'b0; clear_ids = 1'b0;
        set_buttons(4'b0000);
        repeat (2) @(negedge clk);
        check("rst_valid", vote_valid, 0);
        check("rst_ready", ready_led, 0);
        check("rst_busy", busy, 0);
        check("rst_reject", reject, 0);
        check("rst_count", vote_count, 0);
        check("rst_party", vote_party, 0);
        check("rst_id", vote_voter_id, 0);
        reset = 1'b1;
        @(negedge clk);

        // Party 1, id 00001, button held 10 cycles, ack two cycles after valid
        run_ballot(5'd1);
        check("t1_ready", ready_led, 1);
        check("t1_busy", busy, 1);
        set_buttons(4'b0001);
        sb.push_back('{party: 2'd0, id: 5'd1});
        wait_valid("t1", DEB);
        @(negedge clk);
        check("t1_hold_valid", vote_valid, 1);
        check("t1_ready_send", ready_led, 0);
        @(negedge clk);
        check("t1_hold_party", vote_party, 0);
        ack_vote();
        check("t1_valid_drop", vote_valid, 0);
        check("t1_count", vote_count, 1);
        check("t1_busy_rel", busy, 1);
        repeat (3) @(negedge clk);
        check("t1_no_revote", vote_valid, 0);
        release_to_idle("t1");
        check("t1_idle", busy, 0);

        // Party 2 with a 2-cycle glitch before the stable press
        run_ballot(5'd2);
        set_buttons(4'b0010);
        @(negedge clk);
        check("t2_glitch_a", vote_valid, 0);
        @(negedge clk);
        check("t2_glitch_b", vote_valid, 0);
        set_buttons(4'b0000);
        @(negedge clk);
        check("t2_glitch_c", vote_valid, 0);
        set_buttons(4'b0010);
        sb.push_back('{party: 2'd1, id: 5'd2});
        wait_valid("t2", DEB);
        ack_vote();
        release_to_idle("t2");
        check("t2_count", vote_count, 2);

        // Party 3 and 4 together, then party 4 alone; a stray ballot_enable is ignored
        run_ballot(5'd3);
        set_buttons(4'b1100);
        ballot_enable = 1'b1;
        voter_id      = 5'd9;
        @(negedge clk);
        ballot_enable = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_two_pressed", vote_valid, 0);
        check("t3_still_armed", ready_led, 1);
        set_buttons(4'b1000);
        sb.push_back('{party: 2'd3, id: 5'd3});
        wait_valid("t3", DEB);
        ack_vote();
        release_to_idle("t3");
        check("t3_count", vote_count, 3);

        // vote_ack in IDLE is ignored
        ack_vote();
        @(negedge clk);
        check("idle_ack_count", vote_count, 3);

        // Timeout with no press
        begin
            int k;
            run_ballot(5'd4);
            check("t4_ready", ready_led, 1);
            k = 1;
            while (!reject && k < 400) begin
                @(negedge clk);
                k++;
            end
            check("t4_reject_at", k, TMO + 1);
            check("t4_ready_off", ready_led, 0);
            check("t4_busy_off", busy, 0);
            @(negedge clk);
            check("t4_reject_pulse", reject, 0);
            check("t4_count", vote_count, 3);
        end

        // mode drops during SEND, with an ack on the same edge
        run_ballot(5'd5);
        set_buttons(4'b0001);
        sb.push_back('{party: 2'd0, id: 5'd5});
        wait_valid("t5", DEB);
        mode     = 1'b0;
        vote_ack = 1'b1;
        @(negedge clk);
        mode     = 1'b1;
        vote_ack = 1'b0;
        set_buttons(4'b0000);
        check("t5_valid", vote_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_reject", reject, 0);
        check("t5_count", vote_count, 3);
        @(negedge clk);
        check("t5_stay_idle", busy, 0);

`ifdef VOTER_LOCK_EN
        // A voted id is refused until the table is cleared
        clear_ids = 1'b1;
        @(negedge clk);
        clear_ids = 1'b0;
        full_vote("lk1", 5'd5, 2'd2);
        run_ballot(5'd5);
        check("lk_reject", reject, 1);
        check("lk_busy", busy, 0);
        @(negedge clk);
        check("lk_reject_pulse", reject, 0);
        clear_ids = 1'b1;
        @(negedge clk);
        clear_ids = 1'b0;
        run_ballot(5'd5);
        check("lk_reaccept", ready_led, 1);
        mode = 1'b0;
        @(negedge clk);
        mode = 1'b1;
        // Clear on the handshake edge wins over setting the bit
        run_ballot(5'd6);
        set_buttons(4'b0001);
        sb.push_back('{party: 2'd0, id: 5'd6});
        wait_valid("lk2", DEB);
        clear_ids = 1'b1;
        ack_vote();
        clear_ids = 1'b0;
        release_to_idle("lk2");
        run_ballot(5'd6);
        check("lk_clear_wins", ready_led, 1);
        mode = 1'b0;
        @(negedge clk);
        mode = 1'b1;
`endif

        // Drive the counter to saturation
        begin
            int base;
            base = int'(vote_count);
            for (int i = base; i < 256; i++) begin
`ifdef VOTER_LOCK_EN
                clear_ids = 1'b1;
                @(negedge clk);
                clear_ids = 1'b0;
`endif
                full_vote("sat", ID_W'(i), 2'(i));
                if (i == 254) check("sat_255", vote_count, 255);
            end
            check("sat_hold", vote_count, 255);
        end

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
